// File: rtl/ov5647_register_target.sv
// ov5647_register_target: I2C target with 16-bit register addressing, model-ID and mode_select registers
module ov5647_register_target #(
  parameter logic [7:0]  ADDRESS  = 8'h6c,
  parameter logic [15:0] MODEL_ID = 16'h5647,
  parameter int          DEPTH    = 64
) (
  input  logic        clk_in,
  input  logic        reset,
  inout  wire         scl,
  inout  wire         sda,
  output logic        streaming,
  output logic        busy,
  output logic        write_strobe,
  output logic [15:0] write_addr,
  output logic [7:0]  write_data
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_HI, ACK_HI, REG_LO, ACK_LO, WDATA, ACK_W, RDATA, MACK, IGNORE
  } state_t;
  state_t state;
  logic [2:0] scl_s, sda_s;
  logic [7:0] sh, byte_in;
  logic [2:0] cnt;
  logic [15:0] ptr, ptr_nx;
  logic [7:0] mem [DEPTH];
  logic sda_oe, bit_in, scl_rise, scl_fall, start, stop, last;
  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign bit_in = sda_s[1];
  assign scl_rise = scl_s[1] & ~scl_s[2];
  assign scl_fall = ~scl_s[1] & scl_s[2];
  assign start = scl_s[1] & scl_s[2] & ~sda_s[1] & sda_s[2];
  assign stop = scl_s[1] & scl_s[2] & sda_s[1] & ~sda_s[2];
  assign byte_in = {sh[6:0], bit_in};
  assign last = cnt == 3'd7;
  assign ptr_nx = ptr + 16'd1;
  function automatic logic [7:0] rd(input logic [15:0] a);
    return a == 16'h300a ? MODEL_ID[15:8] :
           a == 16'h300b ? MODEL_ID[7:0] :
           a == 16'h0100 ? {7'b0, streaming} : mem[a[AW-1:0]];
  endfunction
  // Ack states enter on the 8th rise, drive on the following fall, and leave on the 9th rise;
  // the next state's first fall then releases sda or drives the first read bit.
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      scl_s <= '1;
      sda_s <= '1;
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      sda_oe <= 1'b0;
      ptr <= '0;
      streaming <= 1'b0;
      busy <= 1'b0;
      write_strobe <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      scl_s <= {scl_s[1:0], scl};
      sda_s <= {sda_s[1:0], sda};
      write_strobe <= 1'b0;
      if (start) begin
        state <= DEV_ADDR;
        cnt <= '0;
        busy <= 1'b1;
        sda_oe <= 1'b0;
      end else if (stop) begin
        state <= IDLE;
        busy <= 1'b0;
        sda_oe <= 1'b0;
      end else if (scl_rise) begin
        cnt <= state inside {DEV_ACK, ACK_HI, ACK_LO, ACK_W, MACK} ? 3'd0 : cnt + 3'd1;
        sh <= byte_in;
        case (state)
          DEV_ADDR: if (last) state <= byte_in[7:1] == ADDRESS[7:1] ? DEV_ACK : IGNORE;
          REG_HI: if (last) begin
            state <= ACK_HI;
            ptr[15:8] <= byte_in;
          end
          REG_LO: if (last) begin
            state <= ACK_LO;
            ptr[7:0] <= byte_in;
          end
          WDATA: if (last) state <= ACK_W;
          RDATA: if (last) state <= MACK;
          DEV_ACK: begin
            state <= sh[0] ? RDATA : REG_HI;
            if (sh[0]) sh <= rd(ptr);
          end
          ACK_HI: state <= REG_LO;
          ACK_LO, ACK_W: state <= WDATA;
          MACK: begin
            state <= bit_in ? IGNORE : RDATA;
            sh <= rd(ptr_nx);
            ptr <= ptr_nx;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        sda_oe <= state == RDATA ? ~sh[7] : state inside {DEV_ACK, ACK_HI, ACK_LO, ACK_W};
        if (state == ACK_W) begin
          write_strobe <= 1'b1;
          write_addr <= ptr;
          write_data <= sh;
          ptr <= ptr_nx;
          if (ptr == 16'h0100) streaming <= sh[0];
          else if (ptr != 16'h300a && ptr != 16'h300b) mem[ptr[AW-1:0]] <= sh;
        end
      end
    end
endmodule

// File: tb/tb_ov5647_register_target.sv
// tb_ov5647_register_target: bit-banged I2C master driving directed transactions against the register target
module tb_ov5647_register_target;
  localparam int Q = 100;
  logic clk_in = 1'b0, reset = 1'b1, scl_lo = 1'b0, sda_lo = 1'b0;
  wire scl, sda;
  logic streaming, busy, write_strobe, busy_mid, released, r;
  logic [15:0] write_addr, v;
  logic [7:0] write_data, b;
  int n_cmp = 0, n_bad = 0, n_strobe = 0, dut_low = 0, acks = 0, s0, d0;
  logic [15:0] addr_q [$];
  assign scl = scl_lo ? 1'b0 : 1'bz;
  assign sda = sda_lo ? 1'b0 : 1'bz;
  pullup (scl);
  pullup (sda);
  always #5 clk_in = ~clk_in;
  ov5647_register_target dut (
    .clk_in(clk_in), .reset(reset), .scl(scl), .sda(sda), .streaming(streaming), .busy(busy),
    .write_strobe(write_strobe), .write_addr(write_addr), .write_data(write_data)
  );
  always @(negedge clk_in) begin
    if (write_strobe) begin
      n_strobe++;
      addr_q.push_back(write_addr);
    end
    if (sda === 1'b0 && !sda_lo) dut_low++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clk_bit(input logic bv, output logic rv);
    sda_lo = !bv; #Q;
    scl_lo = 1'b0; #Q;
    rv = sda; #Q;
    scl_lo = 1'b1; #Q;
  endtask
  task automatic i2c_start;
    sda_lo = 1'b0; #Q;
    scl_lo = 1'b0; #Q;
    sda_lo = 1'b1; #Q;
    scl_lo = 1'b1; #Q;
  endtask
  task automatic i2c_stop;
    sda_lo = 1'b1; #Q;
    scl_lo = 1'b0; #Q;
    sda_lo = 1'b0; #Q;
  endtask
  task automatic send_byte(input logic [7:0] d);
    logic rv;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], rv);
    clk_bit(1'b1, rv);
    if (!rv) acks++;
  endtask
  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic rv;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, rv);
      d[i] = rv;
    end
    clk_bit(!mack, rv);
  endtask
  task automatic wr(input logic [7:0] dev, input logic [15:0] a, input logic [7:0] x0, input logic [7:0] x1, input int n);
    acks = 0;
    i2c_start;
    busy_mid = busy;
    send_byte(dev);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(x0);
    if (n > 1) send_byte(x1);
    i2c_stop;
  endtask
  task automatic rd(input logic [15:0] a, input int n, output logic [15:0] rv);
    logic [7:0] x0, x1;
    acks = 0;
    x1 = 8'h00;
    i2c_start;
    send_byte(8'h6c);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    i2c_start;
    send_byte(8'h6d);
    recv_byte(n > 1, x0);
    if (n > 1) recv_byte(1'b0, x1);
    #Q;
    released = sda;
    rv = n > 1 ? {x0, x1} : {8'h00, x0};
    i2c_stop;
  endtask
  initial begin
    #203 reset = 1'b0;
    #Q;
    chk("rst streaming", streaming, 0);
    chk("rst busy", busy, 0);
    chk("rst strobe", write_strobe, 0);
    chk("rst write_addr", write_addr, 0);
    chk("rst write_data", write_data, 0);
    chk("rst sda", sda, 1);
    s0 = n_strobe;
    wr(8'h6c, 16'h3034, 8'h08, 8'h00, 1);
    chk("w1 busy mid", busy_mid, 1);
    chk("w1 acks", acks, 4);
    chk("w1 strobes", n_strobe - s0, 1);
    chk("w1 write_addr", write_addr, 16'h3034);
    chk("w1 write_data", write_data, 8'h08);
    chk("w1 busy after", busy, 0);
    rd(16'h300a, 2, v);
    chk("id acks", acks, 4);
    chk("id bytes", v, 16'h5647);
    chk("id released", released, 1);
    wr(8'h6c, 16'h0100, 8'h01, 8'h00, 1);
    chk("ms streaming on", streaming, 1);
    rd(16'h0100, 1, v);
    chk("ms readback", v, 16'h0001);
    wr(8'h6c, 16'h0100, 8'h00, 8'h00, 1);
    chk("ms streaming off", streaming, 0);
    wr(8'h6c, 16'h300a, 8'hff, 8'h00, 1);
    chk("ro acks", acks, 4);
    chk("ro strobe addr", write_addr, 16'h300a);
    chk("ro strobe data", write_data, 8'hff);
    rd(16'h300a, 1, v);
    chk("ro readback", v, 16'h0056);
    s0 = n_strobe;
    d0 = dut_low;
    wr(8'h6e, 16'h0020, 8'h5a, 8'h00, 1);
    chk("wa acks", acks, 0);
    chk("wa strobes", n_strobe - s0, 0);
    chk("wa sda driven", dut_low - d0, 0);
    wr(8'h6c, 16'h0020, 8'h5a, 8'h00, 1);
    chk("wa next acks", acks, 4);
    rd(16'h0020, 1, v);
    chk("wa readback", v, 16'h005a);
    wr(8'h6c, 16'h0010, 8'haa, 8'hbb, 2);
    chk("bw acks", acks, 5);
    rd(16'h0010, 2, v);
    chk("bw readback", v, 16'haabb);
    rd(16'h0050, 1, v);
    chk("bw alias", v, 16'h00aa);
    wr(8'h6c, 16'hffff, 8'h11, 8'h22, 2);
    chk("wrap acks", acks, 5);
    chk("wrap first addr", addr_q[$-1], 16'hffff);
    chk("wrap second addr", write_addr, 16'h0000);
    chk("wrap second data", write_data, 8'h22);
    rd(16'h003f, 1, v);
    chk("wrap mem 3f", v, 16'h0011);
    rd(16'h0000, 1, v);
    chk("wrap mem 00", v, 16'h0022);
    wr(8'h6c, 16'h0100, 8'h01, 8'h00, 1);
    chk("mr streaming set", streaming, 1);
    s0 = n_strobe;
    acks = 0;
    i2c_start;
    send_byte(8'h6c);
    send_byte(8'h01);
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, r);
    sda_lo = 1'b0; #Q;
    scl_lo = 1'b0; #(Q/2);
    reset = 1'b1; #1;
    chk("mr sda", sda, 1);
    chk("mr streaming", streaming, 0);
    chk("mr busy", busy, 0);
    #50 reset = 1'b0;
    #(Q/2) scl_lo = 1'b1; #Q;
    i2c_stop;
    chk("mr strobes", n_strobe - s0, 0);
    acks = 0;
    i2c_start;
    send_byte(8'h6d);
    recv_byte(1'b0, b);
    i2c_stop;
    chk("mr ptr read acks", acks, 1);
    chk("mr cleared mem0", b, 8'h00);
    s0 = n_strobe;
    wr(8'h6c, 16'h0030, 8'h77, 8'h00, 1);
    chk("mr write acks", acks, 4);
    chk("mr write strobes", n_strobe - s0, 1);
    rd(16'h0030, 1, v);
    chk("mr readback", v, 16'h0077);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ov5647_register_target.md
# ov5647_register_target

Responder side of the camera control bus: an I2C target with 16-bit register addressing that answers the same transactions the sensor configuration controller issues. Those transactions are 2-byte address writes, data writes, repeated-start reads and sequential bursts. It stands in for the sensor in loopback and simulation benches. It holds a small byte register file, fixed model-ID registers and a mode_select register, and reports every accepted write to fabric.

## Interface
- `ADDRESS`, 8'h6c: device address; bits [7:1] are matched, bit 0 is ignored.
- `MODEL_ID`, 16'h5647: value returned at 0x300a (high byte) and 0x300b (low byte).
- `DEPTH`, 64: bytes of general storage, power of two; indexed by register address [$clog2(DEPTH)-1:0].

Ports:
- `clk_in`  in  1  system clock; must be ≥ 20× SCL rate.
- `reset`  in  1  asynchronous, active-high.
- `scl`  inout  1  bus clock; never driven (no clock stretching).
- `sda`  inout  1  open-drain; drives 1'b0 or 'z only.
- `streaming`  out  1  mode_select bit 0 (register 0x0100).
- `busy`  out  1  high from START to STOP.
- `write_strobe`  out  1  one-cycle pulse per accepted data byte.
- `write_addr`  out  16  register address of the last accepted write.
- `write_data`  out  8  data of the last accepted write.

## Operation
- **Input synchronisation:** `scl` and `sda` each pass through a 2-flop synchroniser, then a third flop for edge detection.
- **START / STOP detection:**
  - START (including repeated START): sda falls while scl is high. Go to DEV_ADDR and clear the bit counter, from any state.
  - STOP: sda rises while scl is high. Go to IDLE and release sda.
- **Bit timing:** bits are sampled on the synchronised scl rising edge, MSB first. Bits are driven after the synchronised scl falling edge.
- **States:**
  - IDLE
  - DEV_ADDR → DEV_ACK
  - REG_HI → ACK_HI
  - REG_LO → ACK_LO
  - WDATA → ACK_W (loops back to WDATA)
  - RDATA → MACK (loops back to RDATA)
  - IGNORE
- **DEV_ACK:**
  - Address byte [7:1] ≠ ADDRESS[7:1]: do not ACK; go to IGNORE until the next START or STOP.
  - Match with R/W = 0: ACK, then REG_HI.
  - Match with R/W = 1: ACK, then RDATA, loading the byte at the current pointer.
- **Register pointer:**
  - 16 bits; REG_HI/REG_LO load it.
  - Persists across transactions; not reset by STOP.
  - Increments after every data byte written or read; wraps 0xffff → 0x0000.
- **ACK_W:** always ACK, then WDATA. Write effects:
  - Pointer 0x0100: `streaming` <= data[0].
  - Pointer 0x300a or 0x300b: write ignored.
  - Any other pointer: mem[pointer low bits] <= data. Addresses alias modulo DEPTH.
  - `write_strobe` pulses in the cycle the ACK is driven, with `write_addr` = pointer and `write_data` = byte. This includes 0x0100 and 0x300a/b writes.
- **Read map:**
  - 0x300a → MODEL_ID[15:8]
  - 0x300b → MODEL_ID[7:0]
  - 0x0100 → {7'b0, streaming}
  - Any other address → mem entry.
- **MACK:** sampled on the 9th scl rise.
  - ACK (sda low): load the next byte and continue in RDATA.
  - NACK (sda high): release sda and go to IGNORE.
- **Extra bytes:** more bytes after the register address in write mode are treated as data (burst write).

## Timing
- **Reset values:**
  - sda = 'z
  - `streaming` = 0, `busy` = 0, `write_strobe` = 0
  - `write_addr` = 16'h0, `write_data` = 8'h0
  - pointer = 0, all mem bytes = 0
  - state = IDLE
- **Reset mid-transfer:** sda is released asynchronously. The block ignores the bus until the next START.
- **Output latency:** an sda output change follows the scl pin edge by 3 clk_in cycles (sync + edge detect + register).
- **ACK window:** sda is held low from the falling edge ending bit 8 until the falling edge ending bit 9.
- **Read drive:** the first data bit is driven at the falling edge ending the ACK clock. sda is released at the falling edge after bit 8 so the master can respond.
- **Simultaneous events:**
  - START/STOP detection takes priority over bit sampling in the same cycle.
  - sda edges while scl is low are data changes, never conditions.
- **`busy`:** set the cycle START is detected; cleared the cycle STOP is detected or on reset.

## Test plan
1. **Single write:** write 0x3034 <= 0x08 to 0x6c. Expect ACK on all 4 bytes, one `write_strobe` with `write_addr` = 0x3034 and `write_data` = 0x08, and `busy` low after STOP.
2. **Model ID read:** write pointer 0x300a, repeated START, read 2 bytes (ACK, then NACK). Expect 0x56 then 0x47, and sda released after the NACK.
3. **mode_select:**
   - Write 0x0100 <= 0x01: `streaming` = 1; read back 0x01.
   - Write 0x0100 <= 0x00: `streaming` = 0.
   - Write 0x300a <= 0xff: ACKed, but a later read still returns 0x56.
4. **Wrong address:** device address 0x6e. Expect sda never driven low, no `write_strobe`, and the following transfer to 0x6c ACKed normally.
5. **Burst and wrap:**
   - Burst write 0x0010 <= 0xAA, 0xBB; read 0x0010 for 2 bytes. Expect 0xAA, 0xBB.
   - Write 0xffff <= 0x11 followed by a second byte 0x22. Expect the second byte's `write_addr` = 0x0000.
6. **Reset mid-operation:** assert `reset` during the 4th bit of a data byte. Expect sda 'z immediately and `streaming` = 0, with no `write_strobe`. A subsequent full write succeeds.
